// File: rtl/posit_quire_acc_4_0_pkg.sv
// Shared widths and types for the posit(4,0) quire accumulator.
// The quire is a 24-bit two's-complement fixed-point value whose LSB weighs 2^-8.
package posit_defines;
    localparam int QUIRE_W_4_0    = 24;
    localparam int QUIRE_FRAC_4_0 = 8;

    localparam logic [QUIRE_W_4_0-1:0] QUIRE_MAX = {1'b0, {(QUIRE_W_4_0-1){1'b1}}};
    localparam logic [QUIRE_W_4_0-1:0] QUIRE_MIN = {1'b1, {(QUIRE_W_4_0-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_OUT   = 2'd2
    } acc_state_t;
endpackage

// File: rtl/posit_quire_acc_4_0_align.sv
// Places one product (1.ffff * 2^scale) onto the quire grid as a signed term.
module posit_quire_align_4_0
    import posit_defines::*;
(
    input  logic [3:0]             fraction_i,
    input  logic [2:0]             scale_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    output logic [QUIRE_W_4_0-1:0] term_o
);
    logic [2:0]             w_shift;
    logic [QUIRE_W_4_0-1:0] w_mag;

    // {1,f} has LSB weight 2^-4, i.e. 2^4 quire LSBs, so scale -4..3 maps to shift 0..7.
    assign w_shift = scale_i + 3'd4;
    assign w_mag   = {{(QUIRE_W_4_0-5){1'b0}}, 1'b1, fraction_i} << w_shift;

    always_comb begin
        term_o = w_mag;
        if (zero_i)
            term_o = '0;
        else if (sign_i)
            term_o = -w_mag;
    end
endmodule

// File: rtl/posit_quire_acc_4_0.sv
// Two-stage dot-product accumulator: align register, saturating quire add, and
// an ACC/FLUSH/OUT FSM that presents one result per dot product with valid/ready.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid_o and the result hold steady until ready_i is seen.
module posit_quire_acc_4_0
    import posit_defines::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             fraction_i,
    input  logic [2:0]             scale_i,
    input  logic                   NaR_i,
    input  logic                   zero_i,
    input  logic                   sign_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic [QUIRE_W_4_0-1:0] quire_o,
    output logic                   NaR_o,
    output logic                   zero_o,
    output logic                   ovf_o,
    output logic                   valid_o,
    input  logic                   ready_i
);
    acc_state_t             r_state, w_next_state;
    logic                   r_s1_valid, r_s1_nar, r_s1_last;
    logic [QUIRE_W_4_0-1:0] r_s1_term;
    logic [QUIRE_W_4_0-1:0] r_quire;
    logic                   r_nar, r_ovf, r_valid_o;

    logic                   w_accept, w_out_hs, w_sat;
    logic [QUIRE_W_4_0-1:0] w_term, w_acc_val;
    logic [QUIRE_W_4_0:0]   w_sum;

    posit_quire_align_4_0 u_align (
        .fraction_i (fraction_i),
        .scale_i    (scale_i),
        .sign_i     (sign_i),
        .zero_i     (zero_i | NaR_i),
        .term_o     (w_term)
    );

    assign ready_o  = (r_state == ST_ACC);
    assign w_accept = valid_i & ready_o;
    assign w_out_hs = r_valid_o & ready_i;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACC:   if (w_accept && last_i) w_next_state = ST_FLUSH;
            ST_FLUSH: if (r_s1_valid && r_s1_last) w_next_state = ST_OUT;
            ST_OUT:   if (w_out_hs) w_next_state = ST_ACC;
            default:  w_next_state = ST_ACC;
        endcase
    end

    // One guard bit detects two's-complement overflow of the 24-bit add.
    assign w_sum     = {r_quire[QUIRE_W_4_0-1], r_quire} + {r_s1_term[QUIRE_W_4_0-1], r_s1_term};
    assign w_sat     = w_sum[QUIRE_W_4_0] ^ w_sum[QUIRE_W_4_0-1];
    assign w_acc_val = w_sat ? (w_sum[QUIRE_W_4_0] ? QUIRE_MIN : QUIRE_MAX)
                             : w_sum[QUIRE_W_4_0-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACC;
            r_s1_valid <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_term  <= '0;
            r_quire    <= '0;
            r_nar      <= 1'b0;
            r_ovf      <= 1'b0;
            r_valid_o  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_term <= w_term;
                r_s1_nar  <= NaR_i;
                r_s1_last <= last_i;
            end
            if (w_out_hs) begin
                r_quire   <= '0;
                r_nar     <= 1'b0;
                r_ovf     <= 1'b0;
                r_valid_o <= 1'b0;
            end else begin
                if (r_s1_valid) begin
                    r_quire <= w_acc_val;
                    r_nar   <= r_nar | r_s1_nar;
                    r_ovf   <= r_ovf | w_sat;
                end
                if (r_state == ST_OUT)
                    r_valid_o <= 1'b1;
            end
        end
    end

    assign valid_o = r_valid_o;
    assign NaR_o   = r_nar;
    assign quire_o = r_nar ? QUIRE_MIN : r_quire;
    assign ovf_o   = r_ovf & ~r_nar;
    assign zero_o  = (r_quire == '0) & ~r_nar & ~r_ovf;
endmodule

// File: tb/tb_posit_quire_acc_4_0.sv
// Self-checking bench for posit_quire_acc_4_0: directed scenarios plus random
// dot products checked against an integer-arithmetic quire model.
module tb_posit_quire_acc_4_0;
    localparam int W = 27;  // {zero, ovf, nar, quire[23:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  fraction_i;
    logic [2:0]  scale_i;
    logic        NaR_i, zero_i, sign_i, valid_i, last_i, ready_i;
    logic        ready_o, NaR_o, zero_o, ovf_o, valid_o;
    logic [23:0] quire_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    longint m_q;
    bit     m_nar, m_ovf;

    posit_quire_acc_4_0 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fraction_i (fraction_i),
        .scale_i    (scale_i),
        .NaR_i      (NaR_i),
        .zero_i     (zero_i),
        .sign_i     (sign_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .quire_o    (quire_o),
        .NaR_o      (NaR_o),
        .zero_o     (zero_o),
        .ovf_o      (ovf_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q   = 0;
        m_nar = 0;
        m_ovf = 0;
    endtask

    // Product value is (16+f)/16 * 2^scale; in quire LSBs (2^-8) that is (16+f)*2^(scale+4).
    task automatic model_beat(input logic [3:0] f, input logic [2:0] s, input logic sg,
                              input logic z, input logic nar);
        longint t;
        int     sh;
        if (nar) begin
            m_nar = 1;
        end else if (!z) begin
            sh = int'($signed(s)) + 4;
            t  = longint'(16 + int'(f)) * (longint'(1) << sh);
            if (sg) t = -t;
            m_q = m_q + t;
            if (m_q > 64'sd8388607) begin
                m_q = 8388607;  m_ovf = 1;
            end else if (m_q < -64'sd8388608) begin
                m_q = -8388608; m_ovf = 1;
            end
        end
    endtask

    task automatic push_expected();
        logic [W-1:0] e;
        logic [63:0]  q;
        q        = m_q;
        e[23:0]  = m_nar ? 24'h800000 : q[23:0];
        e[24]    = m_nar;
        e[25]    = m_nar ? 1'b0 : m_ovf;
        e[26]    = !m_nar && !m_ovf && (m_q == 0);
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [3:0] f, input logic [2:0] s, input logic sg,
                        input logic z, input logic nar, input logic last);
        check_eq("ready_before_beat", {31'd0, ready_o}, 32'd1);
        fraction_i = f; scale_i = s; sign_i = sg; zero_i = z; NaR_i = nar;
        last_i = last; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; last_i = 1'b0;
        model_beat(f, s, sg, z, nar);
        if (last) begin
            push_expected();
            model_reset();
        end
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called 1 time unit after the edge that accepted the last beat.
    task automatic collect(input int hold);
        logic [W-1:0] e, snap;
        int n;
        @(posedge clk); #1;
        check_eq("valid_early", {31'd0, valid_o}, 32'd0);
        @(posedge clk); #1;
        check_eq("valid_at_t2", {31'd0, valid_o}, 32'd1);
        n = 0;
        while (!valid_o && n < 20) begin @(posedge clk); #1; n++; end
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_eq("quire",   {8'd0, quire_o}, {8'd0, e[23:0]});
        check_eq("nar",     {31'd0, NaR_o},  {31'd0, e[24]});
        check_eq("ovf",     {31'd0, ovf_o},  {31'd0, e[25]});
        check_eq("zero",    {31'd0, zero_o}, {31'd0, e[26]});
        check_eq("ready_in_out", {31'd0, ready_o}, 32'd0);
        snap = {zero_o, ovf_o, NaR_o, quire_o};
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("hold_stable", {5'd0, zero_o, ovf_o, NaR_o, quire_o}, {5'd0, snap});
            check_eq("hold_valid", {31'd0, valid_o}, 32'd1);
            check_eq("hold_ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check_eq("valid_after_hs", {31'd0, valid_o}, 32'd0);
        check_eq("ready_after_hs", {31'd0, ready_o}, 32'd1);
        check_eq("zero_after_hs",  {31'd0, zero_o},  32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
        fraction_i = '0; scale_i = '0; sign_i = 1'b0; zero_i = 1'b0; NaR_i = 1'b0;
        model_reset();
        #2;
        check_eq("rst_quire", {8'd0, quire_o}, 32'd0);
        check_eq("rst_zero",  {31'd0, zero_o}, 32'd1);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_nar",   {31'd0, NaR_o}, 32'd0);
        check_eq("rst_ovf",   {31'd0, ovf_o}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready", {31'd0, ready_o}, 32'd1);

        // Single beat 1.5
        beat(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(0);
        // 1.0 + 2.25 back-to-back
        beat(4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(4'b0010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(0);
        // Cancellation to zero, then downstream stall
        beat(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        collect(5);
        // Sticky NaR, then cleared for the next dot product
        beat(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(4'b0010, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1);
        beat(4'b0000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(0);
        // Positive saturation
        repeat (2800) beat(4'b1000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(4'b1000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(0);
        // Reset while FLUSH holds the last term
        beat(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("midrst_quire", {8'd0, quire_o}, 32'd0);
        check_eq("midrst_zero",  {31'd0, zero_o}, 32'd1);
        exp_q.delete();
        model_reset();
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check_eq("midrst_no_valid", {31'd0, valid_o}, 32'd0);
        end
        beat(4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(0);

        // Random dot products with idle gaps and downstream stalls
        for (int d = 0; d < 40; d++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                idle($urandom_range(0, 2));
                beat(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 15) == 0), (b == nb - 1));
            end
            collect($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
